// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC cosine unit.
// Table entries are round(atan(2^-i) * 2^20).
package cordic_pkg;

    localparam int DATA_W_DEF = 22;
    localparam int FRAC_W_DEF = 20;
    localparam int TBL_FRAC   = 20;
    localparam int K_Q20      = 636751;

    localparam int ATAN_TBL [21] = '{
        823550, 486170, 256879, 130396, 65451, 32757, 16383, 8192,
        4096,   2048,   1024,   512,    256,   128,   64,    32,
        16,     8,      4,      2,      1
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational rotation-mode CORDIC step.
// The sign of z selects the rotation direction.
module cordic_micro_rot #(
    parameter int DATA_W = 22
) (
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] y,
    input  logic signed [DATA_W-1:0] z,
    input  logic        [4:0]        i,
    input  logic signed [DATA_W-1:0] atan_i,
    output logic signed [DATA_W-1:0] x_nxt,
    output logic signed [DATA_W-1:0] y_nxt,
    output logic signed [DATA_W-1:0] z_nxt
);

    logic signed [DATA_W-1:0] x_sh;
    logic signed [DATA_W-1:0] y_sh;
    logic                     pos;

    assign x_sh = x >>> i;
    assign y_sh = y >>> i;
    assign pos  = ~z[DATA_W-1];

    // Sums wrap at DATA_W; range is safe for the angles this unit accepts
    assign x_nxt = pos ? (x - y_sh)   : (x + y_sh);
    assign y_nxt = pos ? (y + x_sh)   : (y - x_sh);
    assign z_nxt = pos ? (z - atan_i) : (z + atan_i);

endmodule

// File: rtl/cordic_cosine_iter.sv
// Iterative CORDIC cos(z) with start/done handshake gated by clk_en.
// Define CORDIC_SIN_OUT_EN to also expose sin_out from the y path.
module cordic_cosine_iter
    import cordic_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF,
    parameter int ITERATIONS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [DATA_W-1:0] angle_in,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] cos_out
`ifdef CORDIC_SIN_OUT_EN
    ,
    output logic [DATA_W-1:0] sin_out
`endif
);

    localparam logic signed [DATA_W-1:0] K_INIT = DATA_W'(K_Q20 >>> (TBL_FRAC - FRAC_W));
    localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

    state_t state, state_nxt;
    logic signed [DATA_W-1:0] x, y, z;
    logic signed [DATA_W-1:0] x_nxt, y_nxt, z_nxt;
    logic signed [DATA_W-1:0] atan_i;
    logic        [4:0]        iter;
    logic                     load, step, last;

    assign atan_i = DATA_W'(ATAN_TBL[iter] >>> (TBL_FRAC - FRAC_W));
    assign last   = (iter == LAST_ITER);

    cordic_micro_rot #(.DATA_W(DATA_W)) u_rot (
        .x      (x),
        .y      (y),
        .z      (z),
        .i      (iter),
        .atan_i (atan_i),
        .x_nxt  (x_nxt),
        .y_nxt  (y_nxt),
        .z_nxt  (z_nxt)
    );

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                // Back-to-back: a start seen while done is up is accepted
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            iter    <= '0;
            cos_out <= '0;
`ifdef CORDIC_SIN_OUT_EN
            sin_out <= '0;
`endif
        end else if (clk_en) begin
            state <= state_nxt;
            if (load) begin
                x    <= K_INIT;
                y    <= '0;
                z    <= angle_in;
                iter <= '0;
            end else if (step) begin
                x    <= x_nxt;
                y    <= y_nxt;
                z    <= z_nxt;
                iter <= iter + 5'd1;
            end
            if (step && last) begin
                cos_out <= x_nxt;
`ifdef CORDIC_SIN_OUT_EN
                sin_out <= y_nxt;
`endif
            end
        end
    end

    assign done = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cordic_cosine_iter.sv
// Directed bench for cordic_cosine_iter: latency, accuracy, handshake,
// clk_en stalls and asynchronous reset mid-run.
module tb_cordic_cosine_iter;

    localparam int W   = 22;
    localparam int ITR = 16;
    localparam int TOL = 32;

    logic         clk;
    logic         reset;
    logic         clk_en;
    logic         start;
    logic [W-1:0] angle_in;
    logic         done;
    logic         busy;
    logic [W-1:0] cos_out;
`ifdef CORDIC_SIN_OUT_EN
    logic [W-1:0] sin_out;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    cordic_cosine_iter #(.DATA_W(W), .FRAC_W(20), .ITERATIONS(ITR)) dut (
        .clk      (clk),
        .reset    (reset),
        .clk_en   (clk_en),
        .start    (start),
        .angle_in (angle_in),
        .done     (done),
        .busy     (busy),
        .cos_out  (cos_out)
`ifdef CORDIC_SIN_OUT_EN
        ,
        .sin_out  (sin_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_chk++;
        if (d > tol) $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        else n_pass++;
    endtask

    function automatic int cos_ref(input logic [W-1:0] a);
        real r;
        r = real'($signed(a)) / 1048576.0;
        return $rtoi($floor($cos(r) * 1048576.0 + 0.5));
    endfunction

    function automatic int res();
        return int'($signed(cos_out));
    endfunction

    // Leaves the bench at the negedge just after the accepting edge
    task automatic do_start(input logic [W-1:0] a);
        @(negedge clk);
        angle_in = a;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_lo);
        cyc     = 0;
        busy_lo = 0;
        while (!done && cyc < 200) begin
            if (!busy) busy_lo = 1;
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc, blo, ref_half, dn;
    logic [W-1:0] ang;

    initial begin
        reset    = 1'b1;
        clk_en   = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        #12;
        chk("rst_done", int'(done), 0, 0);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_cos",  res(), 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // angle 0: latency and busy
        do_start(22'h000000);
        wait_done(cyc, blo);
        chk("lat_zero",  cyc + 1, ITR + 1, 0);
        chk("busy_run",  blo, 0, 0);
        chk("busy_done", int'(busy), 1, 0);
        chk("cos_zero",  res(), 1048576, TOL);
        @(negedge clk);
        chk("done_pulse", int'(done), 0, 0);

        do_start(22'h300000);
        wait_done(cyc, blo);
        chk("cos_m1", res(), 566548, TOL);

        do_start(22'h080000);
        wait_done(cyc, blo);
        chk("cos_p05", res(), 920212, TOL);
        ref_half = res();

        // Sweep of upstream-stage angles (x-128)/128
        for (int x = 0; x <= 275; x += 25) begin
            int xv;
            xv  = (x > 250) ? 255 : x;
            ang = W'((xv - 128) * 8192);
            do_start(ang);
            wait_done(cyc, blo);
            chk($sformatf("sweep_x%0d", xv), res(), cos_ref(ang), TOL);
        end

        // Start during RUN is ignored
        do_start(22'h080000);
        repeat (4) @(negedge clk);
        angle_in = 22'h000000;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(cyc, blo);
        chk("ign_lat", cyc, ITR - 5, 0);
        chk("ign_cos", res(), ref_half, 0);

        // Back-to-back start while done is high
        angle_in = 22'h300000;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chk("b2b_nodone", int'(done), 0, 0);
        wait_done(cyc, blo);
        chk("b2b_lat", cyc + 1, ITR + 1, 0);
        chk("b2b_cos", res(), 566548, TOL);

        // clk_en stall of 10 cycles mid-RUN
        do_start(22'h080000);
        repeat (3) @(negedge clk);
        clk_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_busy", int'(busy), 1, 0);
        clk_en = 1'b1;
        wait_done(cyc, blo);
        chk("stall_lat", 3 + 10 + cyc + 1, ITR + 1 + 10, 0);
        chk("stall_cos", res(), ref_half, 0);

        // Async reset mid-RUN
        do_start(22'h080000);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0, 0);
        chk("arst_done", int'(done), 0, 0);
        chk("arst_cos",  res(), 0, 0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("arst_nodone", dn, 0, 0);
        do_start(22'h300000);
        wait_done(cyc, blo);
        chk("arst_lat", cyc + 1, ITR + 1, 0);
        chk("arst_cos2", res(), 566548, TOL);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule

// File: doc/cordic_cosine_iter.md
Name: cordic_cosine_iter

Overview:
- Iterative rotation-mode CORDIC that computes cos(z) for the scaled angle z = (x-128)/128 produced by the fixed-point subtract/divide stage. That angle lies in [-1, 1) rad.
- Sits directly downstream of that stage.
- Its result feeds the x^3·cos multiply path of the accelerator.
- Uses the codebase's multi-cycle custom-instruction handshake: clk_en, start, done.

Parameters:
- DATA_W, 22, signed two's-complement width of the angle and all datapath registers.
- FRAC_W, 20, fractional bits (Q2.20). 1.0 = 0x100000.
- ITERATIONS, 16, number of CORDIC micro-rotations. Legal range 8..20.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  clock qualifier. All state holds when low.
- start  in  1  request. Sampled on a clk_en-qualified edge.
- angle_in  in  DATA_W  signed Q2.20 angle in radians. Captured with start.
- done  out  1  one-cycle pulse: cos_out is valid.
- busy  out  1  high from the accepted start until done falls.
- cos_out  out  DATA_W  signed Q2.20 cosine. Held until the next accepted start.

Behaviour:
- Only clk_en-qualified rising edges count. While clk_en=0, all registers, the state and done hold their values.
- Reset values: done=0, busy=0, cos_out=0, state=IDLE, x/y/z/iter=0. Reset acts immediately and may occur mid-operation; the computation in flight is abandoned and no done is issued.
- FSM states:
  - IDLE: start=1 loads x=K, y=0, z=angle_in, iter=0, then goes to RUN. K=round(0.6072529350·2^20)=636751 (0x09B74F).
  - RUN: one micro-rotation per edge. After the edge that performs iteration ITERATIONS-1, go to DONE and register cos_out=x_next.
  - DONE: done=1 and busy=1 for exactly this cycle. On the next edge go to IDLE. If start=1 on that edge, accept it and go straight to RUN (back-to-back).
- Micro-rotation i:
  - d=+1 if z≥0, else -1.
  - x'=x-d·(y>>>i), y'=y+d·(x>>>i), z'=z-d·ATAN[i].
  - >>> is an arithmetic shift. The result is truncated, and all sums wrap at DATA_W; no saturation is needed for |z|<1.75.
- Latency: if start is accepted at edge E0, done is high in the cycle after edge E(ITERATIONS), i.e. ITERATIONS+1 qualified cycles per result.
- start while busy (RUN) is ignored and not queued. angle_in is only sampled on acceptance.
- ATAN[i] = round(atan(2^-i)·2^20). Example: ATAN[0]=823550.
- Accuracy: |error| ≤ 32 LSB for ITERATIONS=16 over [-1,1).

Optional Feature:
- Macro: CORDIC_SIN_OUT_EN.
- Defined: adds an output port sin_out (DATA_W), registered from y_next alongside cos_out with identical timing and reset value 0.
- Undefined: no sin_out port. The y register still exists (it is needed for the rotation), but y is never output.

Decomposition:
- Package cordic_pkg holds:
  - DATA_W and FRAC_W defaults.
  - the K constant.
  - the ATAN table as a constant array of 21 entries (indices 0..20).
  - the state enum typedef (IDLE, RUN, DONE).
- One sub-module, cordic_micro_rot, is natural. It is a combinational single iteration: inputs x, y, z, i, atan_i; outputs x', y', z'. The top-level block owns the FSM, counter and output registers.

Test Plan:
- angle_in=0x000000 with start for 1 cycle -> done exactly 17 cycles later (ITERATIONS=16); cos_out=1048576 ±32; busy high throughout.
- angle_in=-1.0 (0x300000) -> cos_out=566548 ±32; angle_in=+0.5 (0x080000) -> cos_out=920212 ±32.
- Sweep angle_in=(x-128)/128 for x=0,25,…,250, 255 (as from the upstream stage) -> every cos_out within ±32 LSB of the real-valued cos.
- Start pulsed again at RUN cycle 5 with a different angle -> ignored; result equals the first angle's cosine. Start asserted during DONE -> accepted; the second done follows 17 cycles later.
- clk_en low for 10 cycles mid-RUN -> done delayed by exactly 10 cycles; cos_out unchanged versus the run without the stall.
- reset asserted at RUN cycle 8 (asynchronously, between edges) -> outputs 0 immediately; no done pulse; the next start computes correctly.
